data_demux6: RTL and testbench
==============================

DATA_DEMUX6 -- requirements
Module: data_demux6

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data port.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 IDATA  input  DATA_WIDTH  inbound data word.
REQ-005 SELECT  input  3  destination index: 0..5 selects ODATA1..ODATA6.
REQ-006 IVALID  input  1  inbound word and SELECT are valid.
REQ-007 IREADY  output  1  block accepts the inbound word this cycle.
REQ-008 ODATA1..ODATA6  output  DATA_WIDTH each  per-destination data.
REQ-009 OVALID  output  6  bit k-1 marks ODATAk valid.
REQ-010 OREADY  input  6  bit k-1 marks destination k accepting.
REQ-011 OCOUNT  output  16  count of completed output transfers.
REQ-012 ERR  output  1  invalid-select indication (see Configuration).

Function
REQ-013 Block SHALL hold one entry (data, 3-bit destination) with states EMPTY and FULL.
REQ-014 Input transfer SHALL occur on a cycle with IVALID=1 and IREADY=1; output transfer on a cycle with OVALID[d]=1 and OREADY[d]=1.
REQ-015 IREADY SHALL be 1 in EMPTY, and in FULL exactly when OREADY[held destination]=1 (combinational).
REQ-016 EMPTY + input transfer -> FULL, capturing IDATA and SELECT.
REQ-017 FULL + output transfer without input transfer -> EMPTY.
REQ-018 FULL + simultaneous output and input transfer -> remain FULL, new entry replaces old; no bubble, one word per cycle sustained.
REQ-019 FULL without output transfer SHALL hold data and destination stable; IREADY=0.
REQ-020 Latency SHALL be one cycle: a word accepted in cycle N is first presented in cycle N+1.
REQ-021 OVALID SHALL be one-hot when FULL (bit = held destination) and all-zero when EMPTY.
REQ-022 ODATAk SHALL equal held data when OVALID[k-1]=1, else all-zero.
REQ-023 OREADY bits other than the held destination SHALL have no effect.
REQ-024 OCOUNT SHALL increment by 1 per output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-025 Input changes while IREADY=0 SHALL be ignored.

Reset
REQ-026 RST=1 SHALL immediately force EMPTY, held data 0, held destination 0, OVALID 6'b0, all ODATAk 0, OCOUNT 0, ERR 0, independent of CLK.
REQ-027 Reset mid-operation SHALL discard the held word without producing an output transfer; IREADY=1 while RST=1 and on the first cycle after release.

Configuration
REQ-028 Macro DATA_DEMUX6_ERR_EN SHALL select invalid-SELECT (6 or 7) handling.
REQ-029 Without DATA_DEMUX6_ERR_EN: SELECT 6/7 SHALL route to ODATA1 (destination 0); ERR SHALL be tied to 0.
REQ-030 With DATA_DEMUX6_ERR_EN: an input transfer with SELECT 6/7 SHALL be accepted and dropped (no state change to FULL, OCOUNT unchanged) and ERR SHALL pulse 1 for exactly the following cycle; registered, reset to 0.
REQ-031 With DATA_DEMUX6_ERR_EN, a dropped word arriving during a FULL-state output transfer SHALL still leave the block EMPTY afterwards.

Verification
REQ-032 Reset release, IVALID=1 IDATA=32'hA5A5_0001 SELECT=3, OREADY=6'h3F -> next cycle OVALID=6'b001000, ODATA4=32'hA5A5_0001, others 0; OCOUNT=1 after transfer.
REQ-033 SELECT=1 word accepted, OREADY=0 for 4 cycles -> IREADY=0, OVALID=6'b000010, ODATA2 stable 4 cycles; then OREADY[1]=1 -> transfer, state EMPTY if IVALID=0.
REQ-034 Back-to-back 6 words SELECT 0..5, OREADY=6'h3F -> one word per cycle, OVALID walks 000001..100000, OCOUNT=6.
REQ-035 SELECT=7 IDATA=32'hDEAD_BEEF -> without macro ODATA1=32'hDEAD_BEEF, OVALID=6'b000001; with macro ERR=1 one cycle, OVALID=0, OCOUNT unchanged.
REQ-036 FULL with OREADY=0, assert RST asynchronously mid-cycle -> OVALID=0, ODATA all 0, OCOUNT=0 before next CLK edge; IREADY=1.
REQ-037 Preload OCOUNT to 16'hFFFF via 65535 transfers, one more transfer -> OCOUNT=16'h0000.

Source files
------------

// File: rtl/data_demux6.sv
// data_demux6: single-entry 1-to-6 demultiplexer with valid/ready handshakes.
// One held word (data + destination) is presented on exactly one of six
// outputs; a new word may be accepted in the same cycle the held one leaves,
// so one word per cycle is sustained.
// Optional feature macro: DATA_DEMUX6_ERR_EN. When defined, SELECT values 6/7
// are accepted and dropped, and ERR pulses for one cycle. When undefined,
// they route to destination 0 and ERR stays 0.
//
// state | meaning
// EMPTY | no word held, IREADY=1, OVALID=0
// FULL  | one word held, OVALID one-hot on the held destination
module data_demux6 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IDATA,
    input  logic [2:0]            SELECT,
    input  logic                  IVALID,
    output logic                  IREADY,
    output logic [DATA_WIDTH-1:0] ODATA1,
    output logic [DATA_WIDTH-1:0] ODATA2,
    output logic [DATA_WIDTH-1:0] ODATA3,
    output logic [DATA_WIDTH-1:0] ODATA4,
    output logic [DATA_WIDTH-1:0] ODATA5,
    output logic [DATA_WIDTH-1:0] ODATA6,
    output logic [5:0]            OVALID,
    input  logic [5:0]            OREADY,
    output logic [15:0]           OCOUNT,
    output logic                  ERR
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [2:0]            dest_q, dest_nxt;
    logic [15:0]           count_q;
    logic [7:0]            oready_ext;
    logic                  dest_ready;
    logic                  sel_bad;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  capture;
    logic [2:0]            sel_eff;

    // Handshake qualifiers; only the held destination's ready bit matters.
    always_comb begin
        oready_ext = {2'b00, OREADY};
        dest_ready = oready_ext[dest_q];
        sel_bad    = (SELECT > 3'd5);
        IREADY     = (state == EMPTY) || dest_ready;
        in_xfer    = IVALID && IREADY;
        out_xfer   = (state == FULL) && dest_ready;
`ifdef DATA_DEMUX6_ERR_EN
        capture    = in_xfer && !sel_bad;
        sel_eff    = SELECT;
`else
        capture    = in_xfer;
        sel_eff    = sel_bad ? 3'd0 : SELECT;
`endif
    end

    // State register and held entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= EMPTY;
            data_q <= '0;
            dest_q <= 3'd0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            dest_q <= dest_nxt;
        end
    end

    // Next-state: a dropped word in FULL always coincides with an output
    // transfer (IREADY requires it), so it falls through to EMPTY.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        dest_nxt  = dest_q;
        case (state)
            EMPTY: if (capture) state_nxt = FULL;
            FULL: begin
                if (capture)       state_nxt = FULL;
                else if (out_xfer) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
        if (capture) begin
            data_nxt = IDATA;
            dest_nxt = sel_eff;
        end
    end

    // Output transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)           count_q <= 16'h0000;
        else if (out_xfer) count_q <= count_q + 16'h0001;
    end

    assign OCOUNT = count_q;

`ifdef DATA_DEMUX6_ERR_EN
    logic err_q;

    // One-cycle pulse after an invalid-select word is accepted and dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= in_xfer && sel_bad;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // Destination decode: one-hot valid, data gated to zero elsewhere.
    always_comb begin
        OVALID = (state == FULL) ? (6'b000001 << dest_q) : 6'b000000;
        ODATA1 = OVALID[0] ? data_q : '0;
        ODATA2 = OVALID[1] ? data_q : '0;
        ODATA3 = OVALID[2] ? data_q : '0;
        ODATA4 = OVALID[3] ? data_q : '0;
        ODATA5 = OVALID[4] ? data_q : '0;
        ODATA6 = OVALID[5] ? data_q : '0;
    end

endmodule

// File: tb/tb_data_demux6.sv
// Testbench for data_demux6: stimulus pushes expected (destination, data)
// into a queue on each input transfer; a monitor pops and compares on each
// output transfer. Directed checks cover reset, stalls, wrap and ERR.
module tb_data_demux6;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IDATA = '0;
    logic [2:0]  SELECT = '0;
    logic        IVALID = 1'b0;
    logic        IREADY;
    logic [31:0] ODATA1, ODATA2, ODATA3, ODATA4, ODATA5, ODATA6;
    logic [5:0]  OVALID;
    logic [5:0]  OREADY = '0;
    logic [15:0] OCOUNT;
    logic        ERR;

    data_demux6 #(.DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .IDATA(IDATA), .SELECT(SELECT),
        .IVALID(IVALID), .IREADY(IREADY),
        .ODATA1(ODATA1), .ODATA2(ODATA2), .ODATA3(ODATA3),
        .ODATA4(ODATA4), .ODATA5(ODATA5), .ODATA6(ODATA6),
        .OVALID(OVALID), .OREADY(OREADY), .OCOUNT(OCOUNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    logic [31:0] odata [6];
    always_comb begin
        odata[0] = ODATA1;
        odata[1] = ODATA2;
        odata[2] = ODATA3;
        odata[3] = ODATA4;
        odata[4] = ODATA5;
        odata[5] = ODATA6;
    end

    typedef struct packed {
        logic [2:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest outstanding word.
    always @(negedge CLK) begin
        if (!RST && ((OVALID & OREADY) != 6'b0)) begin
            chk("ovalid_onehot", {63'b0, $onehot(OVALID)}, 64'd1);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: ovalid=%b with no word expected", OVALID);
            end else begin
                mon_e = q.pop_front();
                chk("xfer_dest", {58'b0, OVALID}, {58'b0, 6'b000001 << mon_e.dest});
                for (int k = 0; k < 6; k++) begin
                    if (k == int'(mon_e.dest)) chk("xfer_data", {32'b0, odata[k]}, {32'b0, mon_e.data});
                    else                        chk("idle_data_zero", {32'b0, odata[k]}, 64'd0);
                end
            end
            exp_cnt = exp_cnt + 16'h0001;
        end
    end

    // Offer one word, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [31:0] d, input logic [2:0] s, output int stalls);
        int n = 0;
        IDATA  = d;
        SELECT = s;
        IVALID = 1'b1;
        @(negedge CLK);
        while (!IREADY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        stalls = n;
        if (!IREADY) begin
            total++;
            bad++;
            $display("FAIL send_timeout: iready=%b after %0d cycles required 1", IREADY, n);
        end else begin
`ifdef DATA_DEMUX6_ERR_EN
            if (s <= 3'd5) q.push_back({s, d});
`else
            q.push_back({(s > 3'd5) ? 3'd0 : s, d});
`endif
        end
        @(posedge CLK);
        #1;
        IVALID = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [15:0] exp_oc;

        // Reset state
        #3;
        chk("rst_ireply", {63'b0, IREADY}, 64'd1);
        chk("rst_ovalid", {58'b0, OVALID}, 64'd0);
        chk("rst_ocount", {48'b0, OCOUNT}, 64'd0);
        chk("rst_err", {63'b0, ERR}, 64'd0);
        chk("rst_odata1", {32'b0, ODATA1}, 64'd0);
        #9;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_iready", {63'b0, IREADY}, 64'd1);

        // Basic transfer to destination 4
        OREADY = 6'h3F;
        send(32'hA5A5_0001, 3'd3, st);
        @(negedge CLK);
        chk("basic_ovalid", {58'b0, OVALID}, 64'h08);
        chk("basic_odata4", {32'b0, ODATA4}, 64'hA5A5_0001);
        @(posedge CLK);
        #1;
        chk("basic_ocount", {48'b0, OCOUNT}, 64'd1);

        // Stall on destination 2; other ready bits and new input ignored
        OREADY = 6'h00;
        send(32'h1234_5678, 3'd1, st);
        IVALID = 1'b1;
        IDATA  = 32'hBAD0_0000;
        SELECT = 3'd4;
        OREADY = 6'h3D;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("stall_iready", {63'b0, IREADY}, 64'd0);
            chk("stall_ovalid", {58'b0, OVALID}, 64'h02);
            chk("stall_odata2", {32'b0, ODATA2}, 64'h1234_5678);
        end
        @(posedge CLK);
        #1;
        IVALID = 1'b0;
        OREADY = 6'h02;
        @(posedge CLK);
        #1;
        chk("stall_release_empty", {58'b0, OVALID}, 64'd0);
        chk("stall_release_iready", {63'b0, IREADY}, 64'd1);
        chk("stall_ocount", {48'b0, OCOUNT}, 64'd2);

        // Back-to-back to all six destinations
        OREADY = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            send(32'h3400_0000 + i, 3'(i), st);
            chk("b2b_no_stall", 64'(st), 64'd0);
        end
        @(posedge CLK);
        #1;
        chk("b2b_ocount", {48'b0, OCOUNT}, 64'd8);

        // Invalid select
        send(32'hDEAD_BEEF, 3'd7, st);
`ifdef DATA_DEMUX6_ERR_EN
        @(negedge CLK);
        chk("bad_sel_err", {63'b0, ERR}, 64'd1);
        chk("bad_sel_ovalid", {58'b0, OVALID}, 64'd0);
        @(negedge CLK);
        chk("bad_sel_err_clear", {63'b0, ERR}, 64'd0);
        exp_oc = 16'd8;
`else
        @(negedge CLK);
        chk("bad_sel_ovalid", {58'b0, OVALID}, 64'h01);
        chk("bad_sel_odata1", {32'b0, ODATA1}, 64'hDEAD_BEEF);
        chk("bad_sel_err", {63'b0, ERR}, 64'd0);
        @(posedge CLK);
        #1;
        exp_oc = 16'd9;
`endif
        chk("bad_sel_ocount", {48'b0, OCOUNT}, {48'b0, exp_oc});

        // Invalid-select word arriving while the held word leaves
        send(32'h3100_0002, 3'd2, st);
        send(32'h3100_0BAD, 3'd6, st);
`ifdef DATA_DEMUX6_ERR_EN
        chk("drop_during_xfer_empty", {58'b0, OVALID}, 64'd0);
        exp_oc = exp_oc + 16'd1;
`else
        chk("drop_during_xfer_dest0", {58'b0, OVALID}, 64'h01);
        exp_oc = exp_oc + 16'd2;
`endif
        @(posedge CLK);
        #1;
        chk("drop_ovalid_idle", {58'b0, OVALID}, 64'd0);
        chk("drop_ocount", {48'b0, OCOUNT}, {48'b0, exp_oc});

        // Asynchronous reset while FULL and stalled
        OREADY = 6'h00;
        send(32'h3600_0004, 3'd4, st);
        @(negedge CLK);
        chk("pre_rst_ovalid", {58'b0, OVALID}, 64'h10);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_ovalid", {58'b0, OVALID}, 64'd0);
        chk("async_rst_odata5", {32'b0, ODATA5}, 64'd0);
        chk("async_rst_ocount", {48'b0, OCOUNT}, 64'd0);
        chk("async_rst_iready", {63'b0, IREADY}, 64'd1);
        chk("async_rst_err", {63'b0, ERR}, 64'd0);
        q.delete();
        exp_cnt = 16'h0000;
        @(negedge CLK);
        RST = 1'b0;
        OREADY = 6'h3F;
        @(posedge CLK);
        #1;
        chk("after_rst_iready", {63'b0, IREADY}, 64'd1);
        chk("after_rst_ovalid", {58'b0, OVALID}, 64'd0);

        // Counter wrap
        for (int i = 0; i < 65535; i++) send(32'(i), 3'(i % 6), st);
        @(posedge CLK);
        #1;
        chk("ocount_ffff", {48'b0, OCOUNT}, 64'hFFFF);
        send(32'hFFFF_0000, 3'd5, st);
        @(posedge CLK);
        #1;
        chk("ocount_wrap", {48'b0, OCOUNT}, 64'd0);
        chk("ocount_model", {48'b0, OCOUNT}, {48'b0, exp_cnt});
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
